// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 64;
  localparam int REGFILE_NUM_REGS = 32;

  typedef logic [$clog2(REGFILE_NUM_REGS)-1:0] reg_idx_t;
  typedef logic [REGFILE_DATA_W-1:0]           reg_word_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, writeback
// port, destination claim and outstanding-result count.
interface regfile_sb_if #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     claim_en;
  logic [ADDR_W-1:0]        claim_addr;
  logic [ADDR_W:0]          pend_cnt;

  // Pipeline side: drives reads, writebacks and claims.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_ready, pend_cnt
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_ready, pend_cnt
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-result scoreboard: one pending bit per register plus a running
// count of pending bits maintained by a per-edge +1/0/-1 delta.
// A claim takes priority over a write to the same index (new producer wins).
module regfile_scoreboard #(
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        set_en,
  input  logic [$clog2(NUM_REGS)-1:0] set_idx,
  input  logic                        clr_en,
  input  logic [$clog2(NUM_REGS)-1:0] clr_idx,
  output logic [NUM_REGS-1:0]         pending,
  output logic [$clog2(NUM_REGS):0]   pend_cnt
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = ADDR_W + 1;

  logic [NUM_REGS-1:0] pending_d, pending_q;
  logic [CNT_W-1:0]    pend_cnt_d, pend_cnt_q;
  logic                inc, dec;

  // Next pending vector and count delta; the claim is applied after the
  // clear so a same-index claim+write leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    inc       = 1'b0;
    dec       = 1'b0;
    if (clr_en) begin
      pending_d[clr_idx] = 1'b0;
    end
    if (set_en) begin
      pending_d[set_idx] = 1'b1;
    end
    inc = set_en && !pending_q[set_idx];
    dec = clr_en && pending_q[clr_idx] && !(set_en && (set_idx == clr_idx));
    pend_cnt_d = pend_cnt_q + CNT_W'(inc) - CNT_W'(dec);
  end

  // Scoreboard state; reset discards every in-flight claim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pending  = pending_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read, single-write register file with an integrated
// pending-result scoreboard and optional hardwired zero register.
// Optional feature macro: REGFILE_SB_BYPASS_EN -- when defined, a same-cycle
// writeback is forwarded to matching read ports and marks them ready;
// otherwise readers see stored contents and the new value one cycle later.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = NUM_REGS - 1,
  parameter int ZERO_EN  = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);

  localparam int                ADDR_W   = $clog2(NUM_REGS);
  localparam bit                ZERO_ON  = (ZERO_EN != 0);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]      pending;
  logic [ADDR_W:0]          pend_cnt;
  logic                     wr_ok, claim_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;

  // Writes and claims to the hardwired zero register are dropped here so
  // neither storage, bypass nor the scoreboard ever sees them.
  always_comb begin
    wr_ok    = bus.wr_en    && !(ZERO_ON && (bus.wr_addr    == ZERO_IDX));
    claim_ok = bus.claim_en && !(ZERO_ON && (bus.claim_addr == ZERO_IDX));
  end

  // Next storage contents: single writeback port.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Architectural register storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (claim_ok),
    .set_idx  (bus.claim_addr),
    .clr_en   (wr_ok),
    .clr_idx  (bus.wr_addr),
    .pending  (pending),
    .pend_cnt (pend_cnt)
  );

  // Combinational read ports with ready flag, optional writeback forwarding
  // and zero-register override.
  always_comb begin
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] word;
    logic              rdy;
    rd_data  = '0;
    rd_ready = '0;
    idx      = '0;
    word     = '0;
    rdy      = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      idx  = bus.rd_addr[p*ADDR_W +: ADDR_W];
      word = regs_q[idx];
      rdy  = !pending[idx];
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_ok && (bus.wr_addr == idx)) begin
        word = bus.wr_data;
        rdy  = 1'b1;
      end
`endif
      if (ZERO_ON && (idx == ZERO_IDX)) begin
        word = '0;
        rdy  = 1'b1;
      end
      rd_data[p*DATA_W +: DATA_W] = word;
      rd_ready[p]                 = rdy;
    end
  end

  assign bus.rd_data  = rd_data;
  assign bus.rd_ready = rd_ready;
  assign bus.pend_cnt = pend_cnt;

endmodule
